mpc_qp_admm_mvmult_row_reader: RTL

// - Read-side initiator for the 1R coefficient ROMs (address0/ce0/q0, 1-cycle registered read) in the ADMM QP solver.
// - Streams a row-major H matrix and a vector x, computes y = H*x in fixed point, and emits one saturated result per row.
// - Sits between the H ROM / x buffer and the ADMM update stage; started once per ADMM iteration.

---
 rtl/mpc_fix_pkg.sv | 25 ++
 rtl/mpc_fix_shift_sat.sv | 28 ++
 rtl/mpc_qp_admm_mvmult_row_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mpc_fix_pkg.sv
// Shared Q1.16 fixed-point constants, FSM encoding and helpers for the ADMM mvmult datapaths.
package mpc_fix_pkg;

    localparam int DATA_W = 18;
    localparam int FRAC_W = 16;

    localparam logic [DATA_W-1:0] ONE       = 18'h10000;
    localparam logic [DATA_W-1:0] MINUS_ONE = 18'h30000;
    localparam logic [DATA_W-1:0] SAT_MAX   = 18'h1FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN   = 18'h20000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } rr_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mpc_fix_shift_sat.sv
// Drops FRAC_W fraction bits (floor) from a wide signed accumulator and saturates to DATA_W.
module mpc_fix_shift_sat
    import mpc_fix_pkg::*;
#(
    parameter int IN_W = 39
) (
    input  logic signed [IN_W-1:0] acc,
    output logic [DATA_W-1:0]      q
);

    logic signed [IN_W-1:0]   shifted;
    logic [IN_W-DATA_W:0]     high;

    assign shifted = acc >>> FRAC_W;
    // The value fits only when every bit above the result's sign bit copies it.
    assign high    = shifted[IN_W-1:DATA_W-1];

    always_comb begin
        if ((&high) || !(|high)) begin
            q = shifted[DATA_W-1:0];
        end else if (shifted[IN_W-1]) begin
            q = SAT_MIN;
        end else begin
            q = SAT_MAX;
        end
    end

endmodule

// File: rtl/mpc_qp_admm_mvmult_row_reader.sv
// Streams a row-major H ROM and the x buffer, and emits one saturated Q1.16 dot product per row.
module mpc_qp_admm_mvmult_row_reader
    import mpc_fix_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int N_ROWS  = 3,
    parameter int N_COLS  = 8,
    parameter int XADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  h_address0,
    output logic               h_ce0,
    input  logic [DATA_W-1:0]  h_q0,
    output logic [XADDR_W-1:0] x_address0,
    output logic               x_ce0,
    input  logic [DATA_W-1:0]  x_q0,
    output logic               y_valid,
    output logic [1:0]         y_row,
    output logic [DATA_W-1:0]  y_data
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + clog2(N_COLS);

    localparam logic [ADDR_W-1:0]  FLAT_LAST = ADDR_W'(N_ROWS * N_COLS - 1);
    localparam logic [XADDR_W-1:0] COL_LAST  = XADDR_W'(N_COLS - 1);
    localparam logic [1:0]         ROW_LAST  = 2'(N_ROWS - 1);

    rr_state_t state, state_nx;
    logic [1:0]         drain_cnt;
    logic               issue;
    logic [ADDR_W-1:0]  flat;
    logic [XADDR_W-1:0] col;
    logic [1:0]         row;

    logic               s1_valid, s2_valid;
    logic [XADDR_W-1:0] s1_col, s2_col;
    logic [1:0]         s1_row, s2_row;

    logic signed [PROD_W-1:0] h_ext, x_ext, prod;
    logic signed [ACC_W-1:0]  prod_ext, acc, acc_nx;
    logic [DATA_W-1:0]        sat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (flat == FLAT_LAST) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd2) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        issue = (state == S_RUN);
    end

    assign h_ce0      = issue;
    assign x_ce0      = issue;
    assign h_address0 = flat;
    assign x_address0 = col;

    // Counters stop on the last index so the ROM addresses hold while ce0 is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flat      <= '0;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
        end else begin
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state == S_IDLE && start) begin
                flat <= '0;
                col  <= '0;
                row  <= '0;
            end else if (issue && flat != FLAT_LAST) begin
                flat <= flat + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 2'd1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign h_ext    = {{(PROD_W-DATA_W){h_q0[DATA_W-1]}}, h_q0};
    assign x_ext    = {{(PROD_W-DATA_W){x_q0[DATA_W-1]}}, x_q0};
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // Column 0 starts a fresh row, so no separate clear cycle is needed between rows.
    assign acc_nx   = (s2_col == '0) ? prod_ext : acc + prod_ext;

    mpc_fix_shift_sat #(
        .IN_W(ACC_W)
    ) u_shift_sat (
        .acc(acc_nx),
        .q  (sat_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s2_valid <= 1'b0;
            s2_col   <= '0;
            s2_row   <= '0;
            prod     <= '0;
            acc      <= '0;
            y_valid  <= 1'b0;
            y_row    <= '0;
            y_data   <= '0;
            done     <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_col   <= col;
            s1_row   <= row;
            s2_valid <= s1_valid;
            s2_col   <= s1_col;
            s2_row   <= s1_row;
            y_valid  <= 1'b0;
            done     <= 1'b0;
            if (s1_valid) begin
                prod <= h_ext * x_ext;
            end
            if (s2_valid) begin
                acc <= acc_nx;
                if (s2_col == COL_LAST) begin
                    y_valid <= 1'b1;
                    y_row   <= s2_row;
                    y_data  <= sat_q;
                    done    <= (s2_row == ROW_LAST);
                end
            end
        end
    end

endmodule
